pbit_gibbs_sampler: RTL and testbench

Sequential p-bit update stage that sits directly downstream of the hard-coded p-gate activation blocks (COPY/NOT/AND/OR/HA/FA). It owns the binary node-state register that drives the gate `in` bus. It also sweeps the nodes one at a time, Gibbs-style: it reads the signed activation the gate network produces for the selected node, passes it through a sigmoid LUT, and samples a new node bit against an internal LFSR. Clamping supports inverted operation, for example forcing C=1 on an AND gate to sample consistent inputs.

---
 rtl/pbit_gibbs_sampler.sv | 152 +++++++++++++++
 tb/tb_pbit_gibbs_sampler.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pbit_gibbs_sampler.sv
// Gibbs-style p-bit update stage: sweeps nodes one per cycle, maps the gate
// activation through a sigmoid LUT and samples each bit against a Galois LFSR.

module pbit_cell (
  input  logic clk,
  input  logic rst,
  input  logic upd,
  input  logic clamp_en,
  input  logic clamp_val,
  input  logic smp,
  output logic q
);
  always_ff @(posedge clk) begin
    if (rst)      q <= 1'b0;
    else if (upd) q <= clamp_en ? clamp_val : smp;
  end
endmodule

module pbit_gibbs_sampler #(
  parameter int              N_NODES = 4,
  parameter int              IDX_W   = 2,
  parameter int              LFSR_W  = 16,
  parameter logic [LFSR_W-1:0] SEED  = 16'hACE1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [7:0]         num_sweeps,
  input  logic [1:0]         beta_shift,
  input  logic [N_NODES-1:0] clamp_en,
  input  logic [N_NODES-1:0] clamp_val,
  input  logic [3:0]         act_in,
  output logic [IDX_W-1:0]   node_sel,
  output logic [N_NODES-1:0] state,
  output logic               busy,
  output logic               done,
  output logic [7:0]         sweep_cnt
);
  typedef enum logic [1:0] {IDLE, SAMPLE, DONE} fsm_t;
  typedef struct packed {
    logic [7:0] target;
    logic [1:0] beta;
  } run_cfg_t;

  fsm_t              fsm_q, fsm_d;
  run_cfg_t          cfg_q;
  logic [LFSR_W-1:0] lfsr_q, lfsr_nxt;
  logic signed [7:0] act_ext, scaled_w;
  logic signed [3:0] scaled_sat;
  logic [3:0]        lut_idx;
  logic [7:0]        prob, rnd;
  logic              smp_bit, sampling, last_node, last_sweep;

  // Widen before shifting so |act|*8 cannot wrap before saturation.
  assign act_ext  = {{4{act_in[3]}}, act_in};
  assign scaled_w = act_ext <<< cfg_q.beta;

  always_comb begin
    scaled_sat = scaled_w[3:0];
    if (scaled_w > 8'sd7)       scaled_sat = 4'sd7;
    else if (scaled_w < -8'sd8) scaled_sat = -4'sd8;
  end

  // Offset-binary index: x+8 is the signed value with its MSB flipped.
  assign lut_idx = {~scaled_sat[3], scaled_sat[2:0]};

  always_comb begin
    prob = 8'd0;
    case (lut_idx)
      4'd0:  prob = 8'd0;
      4'd1:  prob = 8'd0;
      4'd2:  prob = 8'd1;
      4'd3:  prob = 8'd2;
      4'd4:  prob = 8'd5;
      4'd5:  prob = 8'd12;
      4'd6:  prob = 8'd30;
      4'd7:  prob = 8'd69;
      4'd8:  prob = 8'd128;
      4'd9:  prob = 8'd187;
      4'd10: prob = 8'd225;
      4'd11: prob = 8'd244;
      4'd12: prob = 8'd251;
      4'd13: prob = 8'd254;
      4'd14: prob = 8'd255;
      4'd15: prob = 8'd255;
      default: prob = 8'd0;
    endcase
  end

  assign rnd        = lfsr_q[7:0];
  assign smp_bit    = rnd < prob;
  assign lfsr_nxt   = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_W'(16'hB400)) : (lfsr_q >> 1);
  assign sampling   = (fsm_q == SAMPLE);
  assign last_node  = (node_sel == IDX_W'(N_NODES-1));
  assign last_sweep = last_node && ((sweep_cnt + 8'd1) == cfg_q.target);
  assign busy       = sampling;
  assign done       = (fsm_q == DONE);

  always_ff @(posedge clk) begin
    if (rst) fsm_q <= IDLE;
    else     fsm_q <= fsm_d;
  end

  always_comb begin
    fsm_d = fsm_q;
    case (fsm_q)
      IDLE:    if (start) fsm_d = (num_sweeps != 8'd0) ? SAMPLE : DONE;
      SAMPLE:  if (last_sweep) fsm_d = DONE;
      DONE:    fsm_d = IDLE;
      default: fsm_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cfg_q     <= '0;
      node_sel  <= '0;
      sweep_cnt <= 8'd0;
      lfsr_q    <= SEED;
    end else begin
      case (fsm_q)
        IDLE: if (start) begin
          sweep_cnt <= 8'd0;
          node_sel  <= '0;
          if (num_sweeps != 8'd0) cfg_q <= '{target: num_sweeps, beta: beta_shift};
        end
        SAMPLE: begin
          lfsr_q <= lfsr_nxt;
          if (last_node) begin
            node_sel  <= '0;
            sweep_cnt <= sweep_cnt + 8'd1;
          end else begin
            node_sel  <= node_sel + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  for (genvar k = 0; k < N_NODES; k++) begin : g_cell
    pbit_cell u_cell (
      .clk       (clk),
      .rst       (rst),
      .upd       (sampling && (node_sel == IDX_W'(k))),
      .clamp_en  (clamp_en[k]),
      .clamp_val (clamp_val[k]),
      .smp       (smp_bit),
      .q         (state[k])
    );
  end
endmodule

// File: tb/tb_pbit_gibbs_sampler.sv
// Bench for pbit_gibbs_sampler: a 4-node and a 3-node (clamped AND) instance,
// each tracked cycle by cycle by a behavioural model of the sweep.

module tb_pbit_gibbs_sampler;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start4, start3;
  logic [7:0] ns4, ns3;
  logic [1:0] b4, b3;
  logic [3:0] ce4, cv4, act4, act3;
  logic [2:0] ce3, cv3;
  logic [1:0] sel4, sel3;
  logic [3:0] st4;
  logic [2:0] st3;
  logic       busy4, busy3, done4, done3;
  logic [7:0] sc4, sc3;

  pbit_gibbs_sampler #(.N_NODES(4), .IDX_W(2)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .num_sweeps(ns4), .beta_shift(b4),
    .clamp_en(ce4), .clamp_val(cv4), .act_in(act4), .node_sel(sel4),
    .state(st4), .busy(busy4), .done(done4), .sweep_cnt(sc4));

  pbit_gibbs_sampler #(.N_NODES(3), .IDX_W(2)) dut3 (
    .clk(clk), .rst(rst), .start(start3), .num_sweeps(ns3), .beta_shift(b3),
    .clamp_en(ce3), .clamp_val(cv3), .act_in(act3), .node_sel(sel3),
    .state(st3), .busy(busy3), .done(done3), .sweep_cnt(sc3));

  // AND-gate activation for the 3-node network (A=node0, B=node1, C=node2).
  always_comb begin
    act3 = 4'd0;
    case (sel3)
      2'd0:    act3 = st3[2] ? 4'd3 : (st3[1] ? 4'hD : 4'd0);
      2'd1:    act3 = st3[2] ? 4'd3 : (st3[0] ? 4'hD : 4'd0);
      default: act3 = (st3[0] & st3[1]) ? 4'd3 : 4'hD;
    endcase
  end

  int n_cmp = 0, n_bad = 0;
  bit chk_en = 0;

  int          lut_tab [16] = '{0,0,1,2,5,12,30,69,128,187,225,244,251,254,255,255};
  int          m_phase [2];   // 0 idle, 1 sweeping, 2 done pulse
  logic [15:0] m_lfsr  [2];
  logic [3:0]  m_state [2];
  int          m_sel [2], m_cnt [2], m_tgt [2], m_beta [2];

  function automatic int prob_of(input int act, input int beta);
    int s;
    s = act * (1 << beta);
    if (s > 7)  s = 7;
    if (s < -8) s = -8;
    return lut_tab[s + 8];
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] v);
    return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
  endfunction

  task automatic model_edge(input int i, input int n, input logic st, input logic [7:0] ns,
                            input logic [1:0] bs, input logic [3:0] ce, input logic [3:0] cv,
                            input int act);
    logic b;
    if (rst) begin
      m_phase[i] = 0; m_lfsr[i] = 16'hACE1; m_state[i] = 4'd0;
      m_sel[i] = 0; m_cnt[i] = 0;
    end else begin
      case (m_phase[i])
        0: if (st) begin
          m_cnt[i] = 0; m_sel[i] = 0;
          if (ns != 0) begin m_tgt[i] = ns; m_beta[i] = bs; m_phase[i] = 1; end
          else m_phase[i] = 2;
        end
        1: begin
          if (ce[m_sel[i]]) b = cv[m_sel[i]];
          else b = (int'(m_lfsr[i] & 16'h00FF) < prob_of(act, m_beta[i]));
          m_state[i][m_sel[i]] = b;
          m_lfsr[i] = lfsr_step(m_lfsr[i]);
          if (m_sel[i] == n - 1) begin
            m_sel[i] = 0; m_cnt[i]++;
            if (m_cnt[i] == m_tgt[i]) m_phase[i] = 2;
          end else m_sel[i]++;
        end
        default: m_phase[i] = 0;
      endcase
    end
  endtask

  always @(posedge clk) begin
    model_edge(0, 4, start4, ns4, b4, ce4, cv4, int'($signed(act4)));
    model_edge(1, 3, start3, ns3, b3, {1'b0, ce3}, {1'b0, cv3}, int'($signed(act3)));
  end

  task automatic check(input int i, input logic [3:0] st, input logic [1:0] sel, input logic bz,
                       input logic dn, input logic [7:0] sc, input logic [15:0] lf);
    logic ebz, edn;
    ebz = (m_phase[i] == 1);
    edn = (m_phase[i] == 2);
    n_cmp++;
    if (st !== m_state[i] || int'(sel) != m_sel[i] || sel === 2'bx || bz !== ebz ||
        dn !== edn || sc !== 8'(m_cnt[i]) || lf !== m_lfsr[i]) begin
      n_bad++;
      $display("FAIL cycle_model[%0d] t=%0t: state=%h sel=%0d busy=%b done=%b cnt=%0d lfsr=%h want state=%h sel=%0d busy=%b done=%b cnt=%0d lfsr=%h",
               i, $time, st, sel, bz, dn, sc, lf, m_state[i], m_sel[i], ebz, edn, m_cnt[i], m_lfsr[i]);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    check(0, st4, sel4, busy4, done4, sc4, dut4.lfsr_q);
    check(1, {1'b0, st3}, sel3, busy3, done3, sc3, dut3.lfsr_q);
  end

  task automatic expect_eq(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // mode: 0 hold act, 1 random act/clamps each slot, 2 ramp act -8..+7
  task automatic run4(input logic [7:0] ns, input logic [1:0] bs, input int mode,
                      input int restart_at, input bit hold_done,
                      output int bc, output int dc, output int da);
    int rp;
    rp = 8; bc = 0; dc = 0; da = -1;
    @(posedge clk); #1;
    start4 = 1'b1; ns4 = ns; b4 = bs;
    for (int k = 1; k < 3000; k++) begin
      @(posedge clk); #1;
      start4 = 1'b0;
      if (k == restart_at) begin start4 = 1'b1; ns4 = 8'd7; end
      if (busy4) begin
        bc++;
        if (mode == 1) begin
          act4 = 4'($urandom_range(0, 15));
          ce4 = 4'($urandom_range(0, 15)); cv4 = 4'($urandom_range(0, 15));
        end else if (mode == 2) begin
          act4 = 4'(rp); rp++;
        end
      end
      if (done4) begin
        dc++; da = k;
        if (hold_done) start4 = 1'b1;
      end
      if (da >= 0 && k >= da + 2) return;
    end
    expect_eq("run4_timeout", 0, 1);
  endtask

  int bc, dc, da, cnt11_dut, cnt11_mdl, c_viol;
  logic [3:0]  st_save;
  logic [15:0] lf_save;
  logic [7:0]  sc_prev;

  initial begin
    rst = 1'b1; start4 = 0; start3 = 0; ns4 = 0; ns3 = 0; b4 = 0; b3 = 0;
    ce4 = 0; cv4 = 0; ce3 = 0; cv3 = 0; act4 = 0;
    @(posedge clk); #1 chk_en = 1;
    @(posedge clk); #1 rst = 1'b0;

    expect_eq("rst_lfsr", int'(dut4.lfsr_q), 16'hACE1);
    expect_eq("rst_state", int'(st4), 0);
    expect_eq("model_lfsr_first_step", int'(lfsr_step(16'hACE1)), 16'hE270);
    expect_eq("model_lut_beta1", prob_of(-1, 1), 30);
    expect_eq("model_lut_sat_hi", prob_of(2, 3), 255);
    expect_eq("model_lut_sat_lo", prob_of(-1, 3), 0);

    // act=0 -> prob 128; rnd sequence E1,70,38,9C gives bits 0,1,1,0
    run4(8'd1, 2'd0, 0, -1, 0, bc, dc, da);
    expect_eq("first_sweep_lfsr", int'(dut4.lfsr_q), 16'h1C4E);
    expect_eq("first_sweep_state", int'(st4), 4'b0110);

    act4 = 4'h8;
    run4(8'd5, 2'd0, 0, -1, 0, bc, dc, da);
    expect_eq("zero_busy_cycles", bc, 20);
    expect_eq("zero_done_count", dc, 1);
    expect_eq("zero_done_cycle", da, 21);
    expect_eq("zero_sweep_cnt", int'(sc4), 5);
    expect_eq("zero_state", int'(st4), 0);

    act4 = 4'd2;
    run4(8'd4, 2'd3, 0, -1, 0, bc, dc, da);
    expect_eq("sat_sweep_cnt", int'(sc4), 4);

    run4(8'd4, 2'd0, 2, -1, 0, bc, dc, da);
    expect_eq("ramp_busy_cycles", bc, 16);

    st_save = st4; lf_save = dut4.lfsr_q;
    run4(8'd0, 2'd1, 0, -1, 0, bc, dc, da);
    expect_eq("ns0_done_cycle", da, 1);
    expect_eq("ns0_busy_cycles", bc, 0);
    expect_eq("ns0_state", int'(st4), int'(st_save));
    expect_eq("ns0_lfsr", int'(dut4.lfsr_q), int'(lf_save));

    act4 = 4'd1;
    run4(8'd2, 2'd1, 0, 3, 1, bc, dc, da);
    expect_eq("busy_start_sweep_cnt", int'(sc4), 2);
    expect_eq("busy_start_busy_cycles", bc, 8);
    expect_eq("start_at_done_ignored", int'(busy4), 0);

    // reset during the 2nd sweep
    act4 = 4'd7;
    @(posedge clk); #1 start4 = 1'b1; ns4 = 8'd3; b4 = 2'd0;
    @(posedge clk); #1 start4 = 1'b0;
    for (int k = 0; k < 50 && !(sc4 == 8'd1 && sel4 == 2'd2); k++) begin
      @(posedge clk); #1;
    end
    expect_eq("midrun_reached", int'(sc4 == 8'd1 && sel4 == 2'd2), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    expect_eq("midrun_rst_state", int'(st4), 0);
    expect_eq("midrun_rst_busy", int'(busy4), 0);
    expect_eq("midrun_rst_cnt", int'(sc4), 0);
    expect_eq("midrun_rst_sel", int'(sel4), 0);
    expect_eq("midrun_rst_lfsr", int'(dut4.lfsr_q), 16'hACE1);

    for (int r = 0; r < 6; r++)
      run4(8'($urandom_range(1, 6)), 2'($urandom_range(0, 3)), 1, -1, 0, bc, dc, da);
    ce4 = 0; cv4 = 0;

    // clamped AND: C forced to 1, A/B should settle mostly at 11
    ce3 = 3'b100; cv3 = 3'b100; cnt11_dut = 0; cnt11_mdl = 0; c_viol = 0;
    @(posedge clk); #1 start3 = 1'b1; ns3 = 8'd200; b3 = 2'd0;
    @(posedge clk); #1 start3 = 1'b0; sc_prev = sc3;
    for (int k = 0; k < 1000 && !done3; k++) begin
      @(posedge clk); #1;
      if (sc3 != sc_prev) begin
        sc_prev = sc3;
        if (st3[1:0] == 2'b11) cnt11_dut++;
        if (m_state[1][1:0] == 2'b11) cnt11_mdl++;
        if (st3[2] !== 1'b1) c_viol++;
      end
    end
    expect_eq("and_done", int'(done3), 1);
    expect_eq("and_sweep_cnt", int'(sc3), 200);
    expect_eq("and_c_clamped", c_viol, 0);
    expect_eq("and_rate_vs_model", cnt11_dut, cnt11_mdl);
    expect_eq("and_rate_high", int'(cnt11_dut > 150), 1);

    repeat (3) @(posedge clk);
    #1 $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
